// File: rtl/proc_pkg.sv
// Shared constants and types for the simple-processor control path.
// Opcodes, state encoding and instruction field positions.
package proc_pkg;

    parameter int n = 16;

    localparam int IR_W = 9;

    localparam int III_MSB = 8;
    localparam int III_LSB = 6;
    localparam int X_MSB   = 5;
    localparam int X_LSB   = 3;
    localparam int Y_MSB   = 2;
    localparam int Y_LSB   = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

endpackage

// File: rtl/proc_control_unit_dec3to8.sv
// 3-bit binary to one-hot 8-bit decoder with enable.
// Output is all zeros when the enable is low.
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle control unit: fetches a 9-bit instruction and sequences
// the bus mux, register/A/G enables and the add/sub mode over T1..T3.
module proc_control_unit #(
    parameter int n = 16
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [n-1:0] DIN,
    input  logic         Run,
    output logic [7:0]   selectR,
    output logic         selectG,
    output logic         selectDin,
    output logic [7:0]   Rin,
    output logic         Ain,
    output logic         Gin,
    output logic         AddSub,
    output logic         Done
);

    import proc_pkg::*;

    state_t          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [2:0] opc;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       rin_we;

    logic unused_din;
    assign unused_din = ^DIN[n-1:IR_W];

    assign opc = ir_q[III_MSB:III_LSB];
    assign rx  = ir_q[X_MSB:X_LSB];
    assign ry  = ir_q[Y_MSB:Y_LSB];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_T1;
                    ir_d    = DIN[IR_W-1:0];
                end
            end
            S_T1: begin
                if (opc == OP_ADD || opc == OP_SUB) begin
                    state_d = S_T2;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T2:    state_d = S_T3;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        selectR   = '0;
        selectG   = 1'b0;
        selectDin = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        AddSub    = 1'b0;
        Done      = 1'b0;
        rin_we    = 1'b0;
        case (state_q)
            S_T1: begin
                case (opc)
                    OP_MV: begin
                        selectR = {5'b0, ry};
                        rin_we  = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_MVI: begin
                        selectDin = 1'b1;
                        rin_we    = 1'b1;
                        Done      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        selectR = {5'b0, rx};
                        Ain     = 1'b1;
                    end
                    default: Done = 1'b1;
                endcase
            end
            S_T2: begin
                selectR = {5'b0, ry};
                Gin     = 1'b1;
                AddSub  = (opc == OP_SUB);
            end
            S_T3: begin
                selectG = 1'b1;
                rin_we  = 1'b1;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    dec3to8 u_rin_dec (
        .w  (rx),
        .en (rin_we),
        .y  (Rin)
    );

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit with hand-computed outputs.
// Outputs are packed as {selectR,selectG,selectDin,Rin,Ain,Gin,AddSub,Done}.
module tb_proc_control_unit;

    logic        Clock;
    logic        Resetn;
    logic [15:0] DIN;
    logic        Run;
    logic [7:0]  selectR;
    logic        selectG;
    logic        selectDin;
    logic [7:0]  Rin;
    logic        Ain;
    logic        Gin;
    logic        AddSub;
    logic        Done;

    int n_tests;
    int n_fail;

    proc_control_unit #(.n(16)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .DIN       (DIN),
        .Run       (Run),
        .selectR   (selectR),
        .selectG   (selectG),
        .selectDin (selectDin),
        .Rin       (Rin),
        .Ain       (Ain),
        .Gin       (Gin),
        .AddSub    (AddSub),
        .Done      (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [21:0] pk(
        input logic [7:0] sr, input logic sg, input logic sd,
        input logic [7:0] rin, input logic a, input logic g,
        input logic as, input logic d);
        return {sr, sg, sd, rin, a, g, as, d};
    endfunction

    function automatic logic [21:0] outs();
        return {selectR, selectG, selectDin, Rin, Ain, Gin, AddSub, Done};
    endfunction

    task automatic check(input string tag, input logic [21:0] got,
                         input logic [21:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    localparam logic [21:0] ZERO = 22'h0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Resetn  = 1'b0;
        Run     = 1'b0;
        DIN     = '0;
        #3;
        check("reset_outs", outs(), ZERO);
        tick();
        check("reset_held", outs(), ZERO);
        #2 Resetn = 1'b1;
        tick();
        check("idle_norun", outs(), ZERO);

        // mv R3 <- R5
        DIN = 16'b000_011_101; Run = 1'b1;
        tick();
        Run = 1'b0;
        check("mv_t1", outs(), pk(8'd5, 0, 0, 8'h08, 0, 0, 0, 1));
        tick();
        check("mv_idle", outs(), ZERO);

        // mvi R7 <- 0x1234
        DIN = 16'b001_111_000; Run = 1'b1;
        tick();
        DIN = 16'h1234; Run = 1'b0;
        check("mvi_t1", outs(), pk(8'd0, 0, 1, 8'h80, 0, 0, 0, 1));
        tick();
        check("mvi_idle", outs(), ZERO);

        // add R1 <- R1 + R2
        DIN = 16'b010_001_010; Run = 1'b1;
        tick();
        Run = 1'b0;
        check("add_t1", outs(), pk(8'd1, 0, 0, 8'h00, 1, 0, 0, 0));
        tick();
        check("add_t2", outs(), pk(8'd2, 0, 0, 8'h00, 0, 1, 0, 0));
        tick();
        check("add_t3", outs(), pk(8'd0, 1, 0, 8'h02, 0, 0, 0, 1));
        tick();
        check("add_idle", outs(), ZERO);

        // sub R4 <- R4 - R0, Run held, then mv R2 <- R6 queued
        DIN = 16'b011_100_000; Run = 1'b1;
        tick();
        DIN = 16'b000_010_110;
        check("sub_t1", outs(), pk(8'd4, 0, 0, 8'h00, 1, 0, 0, 0));
        tick();
        check("sub_t2", outs(), pk(8'd0, 0, 0, 8'h00, 0, 1, 1, 0));
        tick();
        check("sub_t3", outs(), pk(8'd0, 1, 0, 8'h10, 0, 0, 0, 1));
        tick();
        check("sub_gap_idle", outs(), ZERO);
        tick();
        Run = 1'b0;
        check("mv2_t1", outs(), pk(8'd6, 0, 0, 8'h04, 0, 0, 0, 1));
        tick();
        check("mv2_idle", outs(), ZERO);

        // NOP opcode 111
        DIN = 16'b111_101_011; Run = 1'b1;
        tick();
        Run = 1'b0;
        check("nop_t1", outs(), pk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1));
        tick();
        check("nop_idle", outs(), ZERO);

        // reset asserted while in T2 of an add
        DIN = 16'b010_001_010; Run = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        check("rst_pre_t2", outs(), pk(8'd2, 0, 0, 8'h00, 0, 1, 0, 0));
        #2 Resetn = 1'b0;
        #1;
        check("rst_async", outs(), ZERO);
        tick();
        check("rst_hold", outs(), ZERO);
        #2 Resetn = 1'b1;
        tick();
        check("rst_rel_idle", outs(), ZERO);
        tick();
        check("rst_rel_idle2", outs(), ZERO);

        // first Run after reset fetches
        DIN = 16'b000_000_111; Run = 1'b1;
        tick();
        Run = 1'b0;
        check("post_rst_mv", outs(), pk(8'd7, 0, 0, 8'h01, 0, 0, 0, 1));
        tick();
        check("post_rst_idle", outs(), ZERO);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
